// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch and data
// load/store, tracking the single in-flight access across the fixed read latency.
module mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MEM_LAT        = 2,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(MAX_DATA_BURST + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_owner_d;
  logic          r_owner_we;
  logic [SW-1:0] r_streak;

  logic w_issue;
  logic w_pick_d;
  logic w_burst_full;

  // Grants are combinational so the winner reaches the memory in its issue cycle;
  // rst masks them so a reset cycle never starts an access.
  assign w_burst_full = (r_streak == SW'(MAX_DATA_BURST));
  assign w_issue      = !rst && (r_state == S_IDLE) && (if_req || d_req);
  assign w_pick_d     = d_req && (!if_req || !w_burst_full);

  assign d_gnt  = w_issue && w_pick_d;
  assign if_gnt = w_issue && !w_pick_d;
  assign mem_en = w_issue;

  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a latch behind.
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  // NOTE: all state here uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_streak   <= '0;
      r_owner_d  <= 1'b0;
      r_owner_we <= 1'b0;
      if_rvalid  <= 1'b0;
      d_rvalid   <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state    <= S_BUSY;
            r_cnt      <= 4'(MEM_LAT);
            r_owner_d  <= w_pick_d;
            r_owner_we <= w_pick_d && d_we;
            // Streak only grows while fetch is actually waiting behind data.
            if (w_pick_d && if_req)
              r_streak <= w_burst_full ? r_streak : r_streak + 1'b1;
            else
              r_streak <= '0;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_IDLE;
            if (r_owner_d) begin
              d_rvalid <= 1'b1;
              d_rdata  <= r_owner_we ? '0 : mem_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand sequences for multi-cycle corners,
// and randomized traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int MEM_LAT = 2;
  localparam int MAXB    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(MEM_LAT), .MAX_DATA_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %s expected %s", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Physical memory: single port, read data appears two cycles after mem_en,
  // junk otherwise so a mistimed capture shows up.
  logic [31:0] phys [256];
  logic [31:0] p1 = '0, p2 = '0, cyc = '0;
  assign mem_rdata = p2;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en && !mem_we) p1 <= phys[mem_addr[9:2]];
    else                   p1 <= 32'hBAD0_0000 ^ cyc;
    if (mem_en && mem_we)  phys[mem_addr[9:2]] <= mem_wdata;
    p2 <= p1;
  end

  // Reference model: one transaction in flight, tracked by cycles remaining;
  // read data comes from a shadow copy of the memory updated at store issue.
  logic [31:0] ref_mem [256];
  int          m_busy = 0, m_streak = 0;
  logic        m_own_d = 1'b0, m_if_rv = 1'b0, m_d_rv = 1'b0;
  logic [31:0] m_pend = '0, m_if_rd = '0, m_d_rd = '0;
  logic        mon_chk = 1'b0;

  initial forever begin
    logic        can, pd;
    logic [31:0] a;
    logic [133:0] act, exp;
    @(negedge clk);
    can = !rst && (m_busy == 0) && (if_req || d_req);
    pd  = d_req && (!if_req || (m_streak < MAXB));
    a   = pd ? d_addr : if_addr;
    exp = {can && !pd, can && pd, can, can && pd && d_we, can ? a : 32'h0,
           (can && pd) ? d_wdata : 32'h0, m_if_rv, m_d_rv, m_if_rd, m_d_rd};
    act = {if_gnt, d_gnt, mem_en, mem_we, mem_addr, mem_wdata, if_rvalid, d_rvalid, if_rdata, d_rdata};
    if (mon_chk) check("monitor", 160'(act), 160'(exp));
    if (rst) begin
      m_busy = 0; m_streak = 0; m_if_rv = 0; m_d_rv = 0; m_if_rd = '0; m_d_rd = '0;
    end else begin
      m_if_rv = 1'b0;
      m_d_rv  = 1'b0;
      if (m_busy > 0) begin
        if (m_busy == 1) begin
          if (m_own_d) begin m_d_rv = 1'b1; m_d_rd = m_pend; end
          else         begin m_if_rv = 1'b1; m_if_rd = m_pend; end
        end
        m_busy--;
      end
      if (can) begin
        m_busy  = MEM_LAT;
        m_own_d = pd;
        if (pd && d_we) begin
          ref_mem[a[9:2]] = d_wdata;
          m_pend = '0;
        end else begin
          m_pend = ref_mem[a[9:2]];
        end
        if (pd && if_req) m_streak = (m_streak < MAXB) ? m_streak + 1 : MAXB;
        else              m_streak = 0;
      end
    end
  end

  typedef struct {
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        exp_d;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  // Holds fetch and data requests high and records the grant order and spacing.
  task automatic burst(output string ord, output int bad_gap);
    int last;
    last = -1; ord = ""; bad_gap = 0;
    if_req = 1'b1; if_addr = 32'h54; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50;
    for (int k = 0; k < 30; k++) begin
      #3;
      if (d_gnt)  ord = {ord, "D"};
      if (if_gnt) ord = {ord, "F"};
      if (d_gnt || if_gnt) begin
        if (last >= 0 && k - last != MEM_LAT + 1) bad_gap++;
        last = k;
      end
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    string ord;
    int    bad_gap;
    logic  g_if, g_d, stray;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0,  32'h0,        1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0,  32'h40, 32'h1234,     1'b1, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0,  32'h40, 32'h0,        1'b1, 32'h1234};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h20, 32'h80, 32'h0,        1'b1, 32'hC0DE0080};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h20, 32'h0,  32'h0,        1'b0, 32'hC0DE0020};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h20, 32'h24, 32'h55AA55AA, 1'b1, 32'h0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h0,  32'h24, 32'h0,        1'b1, 32'h55AA55AA};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h24, 32'h0,  32'h0,        1'b0, 32'h55AA55AA};

    for (int i = 0; i < 256; i++) begin
      phys[i]    = 32'hC0DE0000 + 32'(i * 4);
      ref_mem[i] = 32'hC0DE0000 + 32'(i * 4);
    end
    phys[4]    = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;

    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    tick();
    mon_chk = 1'b1;
    check("reset_outputs", 160'({if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                                 mem_en, mem_we, mem_addr, mem_wdata}), 160'(0));
    tick();
    rst = 1'b0;

    // Single transactions from idle; a losing request is withdrawn after the issue cycle.
    for (int r = 0; r < 8; r++) begin
      if_req = vecs[r].if_req; if_addr = vecs[r].if_addr;
      d_req = vecs[r].d_req; d_we = vecs[r].d_we; d_addr = vecs[r].d_addr; d_wdata = vecs[r].d_wdata;
      #3;
      check($sformatf("row%0d_issue", r), 160'({if_gnt, d_gnt, mem_en, mem_we, mem_addr}),
            160'({!vecs[r].exp_d, vecs[r].exp_d, 1'b1, vecs[r].exp_d && vecs[r].d_we,
                  vecs[r].exp_d ? vecs[r].d_addr : vecs[r].if_addr}));
      tick();
      if_req = 1'b0; d_req = 1'b0;
      tick();
      tick();
      #3;
      check($sformatf("row%0d_resp", r),
            160'({if_rvalid, d_rvalid, vecs[r].exp_d ? d_rdata : if_rdata}),
            160'({!vecs[r].exp_d, vecs[r].exp_d, vecs[r].exp_rdata}));
      tick();
    end

    // Store immediately followed by a load of the same word, issued on the completion cycle.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h48; d_wdata = 32'hA5A5F00D;
    #3;
    check("store_issue", 160'({d_gnt, mem_we, mem_wdata}), 160'({1'b1, 1'b1, 32'hA5A5F00D}));
    tick();
    d_we = 1'b0;
    #3;
    check("busy_no_gnt", 160'({d_gnt, mem_en}), 160'(0));
    tick();
    tick();
    #3;
    check("store_done_load_issue", 160'({d_rvalid, d_rdata, d_gnt}), 160'({1'b1, 32'h0, 1'b1}));
    tick();
    d_req = 1'b0;
    tick();
    tick();
    #3;
    check("load_after_store", 160'({d_rvalid, d_rdata}), 160'({1'b1, 32'hA5A5F00D}));
    tick();

    // Simultaneous requests: data first, fetch three cycles later.
    if_req = 1'b1; if_addr = 32'h30; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h34;
    #3;
    check("both_data_first", 160'({if_gnt, d_gnt}), 160'({1'b0, 1'b1}));
    tick();
    d_req = 1'b0;
    tick();
    tick();
    #3;
    check("both_fetch_next", 160'({if_gnt, d_gnt, mem_addr}), 160'({1'b1, 1'b0, 32'h30}));
    tick();
    if_req = 1'b0;
    repeat (3) tick();

    burst(ord, bad_gap);
    check_str("burst_order", ord, "DDDDFDDDDF");
    check("burst_spacing", 160'(bad_gap), 160'(0));

    // Reset one cycle into a load: the response is dropped and arbitration resumes at once.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    #3;
    check("rst_load_issue", 160'(d_gnt), 160'(1));
    tick();
    d_req = 1'b0; rst = 1'b1;
    #3;
    check("rst_cycle_quiet", 160'({if_gnt, d_gnt, mem_en}), 160'(0));
    tick();
    rst = 1'b0; if_req = 1'b1; if_addr = 32'h10;
    #3;
    check("after_rst_grant", 160'({if_gnt, d_gnt, if_rvalid, d_rvalid, if_rdata, d_rdata, mem_addr}),
          160'({4'b1000, 64'h0, 32'h10}));
    tick();
    if_req = 1'b0;
    #3;
    check("rst_no_stale_rvalid", 160'(d_rvalid), 160'(0));
    tick();
    tick();
    #3;
    check("after_rst_fetch", 160'({if_rvalid, if_rdata, d_rvalid}), 160'({1'b1, 32'hDEADBEEF, 1'b0}));
    tick();

    // Fetch withdrawn while data is busy; the next lone data grant must reset the streak.
    stray = 1'b0;
    if_req = 1'b1; if_addr = 32'h60; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h64; d_wdata = 32'h77;
    #3;
    check("drop_issue", 160'({if_gnt, d_gnt, mem_we}), 160'({1'b0, 1'b1, 1'b1}));
    tick();
    d_req = 1'b0;
    #3;
    stray = stray | if_gnt;
    tick();
    if_req = 1'b0;
    #3;
    stray = stray | if_gnt | if_rvalid;
    tick();
    d_req = 1'b1; d_we = 1'b0;
    #3;
    check("drop_store_done", 160'({if_rvalid, d_rvalid, d_rdata, if_gnt, d_gnt}),
          160'({1'b0, 1'b1, 32'h0, 1'b0, 1'b1}));
    tick();
    d_req = 1'b0;
    #3;
    stray = stray | if_gnt | if_rvalid;
    tick();
    #3;
    stray = stray | if_gnt | if_rvalid;
    tick();
    #3;
    check("drop_load_done", 160'({if_rvalid, d_rvalid, d_rdata}), 160'({1'b0, 1'b1, 32'h77}));
    check("drop_no_fetch", 160'(stray), 160'(0));
    tick();
    burst(ord, bad_gap);
    check_str("streak_cleared", ord, "DDDDFDDDDF");

    // Random traffic obeying the hold-until-grant rule, with occasional drops and resets.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      g_if = if_gnt;
      g_d  = d_gnt;
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 99) == 0);
      if (!if_req || g_if) begin
        if_req  = 1'($urandom_range(0, 1));
        if_addr = 32'($urandom_range(0, 15) * 4);
      end else if ($urandom_range(0, 9) == 0) begin
        if_req = 1'b0;
      end
      if (!d_req || g_d) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 32'($urandom_range(0, 15) * 4);
        d_wdata = $urandom;
      end else if ($urandom_range(0, 9) == 0) begin
        d_req = 1'b0;
      end
    end
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
